// File: rtl/bf_phase_sequencer.sv
// bf_phase_sequencer
//   Sequences each core instruction through three equal-length phases:
//   READ (RAM read), DECODE (core decode/execute) and WRITE (RAM write and
//   address update). Each phase lasts DIV_RATIO clk cycles. A WAIT_SFR stall
//   is inserted between DECODE and WRITE when the instruction writes the SFR
//   and the SFR is not ready.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   run          level, free-run instructions while high
//   step         level, each rising edge requests one instruction
//   finish       program ended (ROM overrun)
//   dout         current instruction writes the SFR
//   sfr_ready    SFR can accept a write this cycle
//   ph_read      one-cycle pulse on the first cycle of READ
//   ph_decode    one-cycle pulse on the first cycle of DECODE
//   ph_write     one-cycle pulse on the first cycle of WRITE
//   ram_we       RAM write enable (same as ph_write)
//   sfr_we       SFR write strobe (ph_write of an SFR-writing instruction)
//   busy         instruction in progress
//   halted       program finished, held until reset
//   instr_count  retired instruction count, saturating

module bf_phase_sequencer #(
    parameter int unsigned DIV_RATIO = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic        finish,
    input  logic        dout,
    input  logic        sfr_ready,
    output logic        ph_read,
    output logic        ph_decode,
    output logic        ph_write,
    output logic        ram_we,
    output logic        sfr_we,
    output logic        busy,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StDecode,
        StWaitSfr,
        StWrite,
        StDone
    } state_e;

    localparam logic [15:0] PhaseLoad = 16'(DIV_RATIO - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        dout_q;
    logic        step_q;
    logic        pending_q;

    logic        step_edge;
    logic        step_req;

    assign step_edge = step & ~step_q;
    // A step edge arriving in IDLE starts an instruction in the same cycle.
    assign step_req  = pending_q | step_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dout_q      <= 1'b0;
            step_q      <= 1'b0;
            pending_q   <= 1'b0;
            ph_read     <= 1'b0;
            ph_decode   <= 1'b0;
            ph_write    <= 1'b0;
            ram_we      <= 1'b0;
            sfr_we      <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            step_q    <= step;
            ph_read   <= 1'b0;
            ph_decode <= 1'b0;
            ph_write  <= 1'b0;
            ram_we    <= 1'b0;
            sfr_we    <= 1'b0;

            // Only one request can be pending; further edges are dropped.
            if (step_edge) begin
                pending_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (finish) begin
                        state_q   <= StDone;
                        halted    <= 1'b1;
                        pending_q <= 1'b0;
                    end else if (run || step_req) begin
                        state_q   <= StRead;
                        cnt_q     <= PhaseLoad;
                        ph_read   <= 1'b1;
                        busy      <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end

                StRead: begin
                    if (cnt_q == 16'd0) begin
                        state_q   <= StDecode;
                        cnt_q     <= PhaseLoad;
                        ph_decode <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                StDecode: begin
                    if (cnt_q == 16'd0) begin
                        dout_q <= dout;
                        if (dout && !sfr_ready) begin
                            state_q <= StWaitSfr;
                        end else begin
                            state_q  <= StWrite;
                            cnt_q    <= PhaseLoad;
                            ph_write <= 1'b1;
                            ram_we   <= 1'b1;
                            sfr_we   <= dout;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                StWaitSfr: begin
                    if (sfr_ready) begin
                        state_q  <= StWrite;
                        cnt_q    <= PhaseLoad;
                        ph_write <= 1'b1;
                        ram_we   <= 1'b1;
                        sfr_we   <= dout_q;
                    end
                end

                StWrite: begin
                    if (cnt_q == 16'd0) begin
                        if (instr_count != 16'hFFFF) begin
                            instr_count <= instr_count + 16'd1;
                        end
                        if (finish) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            halted  <= 1'b1;
                        end else if (run) begin
                            state_q <= StRead;
                            cnt_q   <= PhaseLoad;
                            ph_read <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                StDone: begin
                    // Absorbing; stale step requests are discarded.
                    pending_q <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule
